// File: rtl/npc_axi_pkg.sv
// rtl/npc_axi_pkg.sv - shared response codes, size codes and FSM states for the NPC AXI responders
package npc_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] WUSER_8B = 4'b1000;
    localparam logic [3:0] WUSER_4B = 4'b0100;
    localparam logic [3:0] WUSER_2B = 4'b0010;
    localparam logic [3:0] WUSER_1B = 4'b0001;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_e;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } w_state_e;

    // Number of bytes carried by a write; unknown codes are treated as a full word.
    function automatic logic [3:0] size_bytes(input logic [3:0] wuser);
        case (wuser)
            WUSER_4B: size_bytes = 4'd4;
            WUSER_2B: size_bytes = 4'd2;
            WUSER_1B: size_bytes = 4'd1;
            default:  size_bytes = 4'd8;
        endcase
    endfunction

    // Byte-enable pattern for a write starting at lane 0.
    function automatic logic [7:0] size_mask(input logic [3:0] wuser);
        case (wuser)
            WUSER_8B: size_mask = 8'hFF;
            WUSER_4B: size_mask = 8'h0F;
            WUSER_2B: size_mask = 8'h03;
            WUSER_1B: size_mask = 8'h01;
            default:  size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/sram_1r1w.sv
// rtl/sram_1r1w.sv - 64-bit word array with byte-enable write and combinational read
module sram_1r1w #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wbe,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [63:0] mem_q [DEPTH];

    // Byte-lane write; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (wbe[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI-style on-chip RAM responder with burst reads and masked single-beat writes
module axi_sram_slave
    import npc_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LATENCY  = 1
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        ARVALID,
    output logic        ARREADY,
    input  logic [31:0] ARADDR,
    input  logic [7:0]  ARLEN,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [63:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RLAST,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] AWADDR,
    input  logic        WVALID,
    output logic        WREADY,
    input  logic [63:0] WDATA,
    input  logic        WLAST,
    input  logic [3:0]  WUSER,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [1:0]  BRESP
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [7:0] WAIT_INIT = (RD_LATENCY > 1) ? 8'(RD_LATENCY - 2) : 8'd0;

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> 3) < 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 3);
    endfunction

    // Read side state
    r_state_e    r_state_q, r_state_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [7:0]  r_beats_q, r_beats_d;
    logic [7:0]  r_wait_q, r_wait_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        r_load;
    logic [31:0] r_fetch_addr;

    // Write side state
    w_state_e    w_state_q, w_state_d;
    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  wuser_q, wuser_d;
    logic        wlast_q, wlast_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;

    logic        aw_hs, w_hs;
    logic [31:0] eff_addr;
    logic [63:0] eff_data;
    logic [3:0]  eff_user;
    logic        eff_last;
    logic [2:0]  lane;
    logic        crosses;

    // Memory ports
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [7:0]       mem_wbe;
    logic [63:0]      mem_wdata;
    logic [63:0]      mem_rdata;

    sram_1r1w #(
        .DEPTH(DEPTH_WORDS),
        .AW   (IDX_W)
    ) u_sram (
        .clk  (ACLK),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wbe  (mem_wbe),
        .wdata(mem_wdata),
        .raddr(word_idx(r_fetch_addr)),
        .rdata(mem_rdata)
    );

    // Read FSM: accept a burst, wait out the latency, then stream beats with no bubbles.
    always_comb begin
        r_state_d    = r_state_q;
        r_addr_d     = r_addr_q;
        r_beats_d    = r_beats_q;
        r_wait_d     = r_wait_q;
        arready_d    = arready_q;
        rvalid_d     = rvalid_q;
        rlast_d      = rlast_q;
        rdata_d      = rdata_q;
        rresp_d      = rresp_q;
        r_load       = 1'b0;
        r_fetch_addr = r_addr_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    arready_d = 1'b0;
                    r_addr_d  = ARADDR & ~32'h7;
                    r_beats_d = ARLEN;
                    if (RD_LATENCY == 1) begin
                        r_state_d    = R_DATA;
                        r_load       = 1'b1;
                        r_fetch_addr = ARADDR & ~32'h7;
                        rlast_d      = (ARLEN == 8'd0);
                    end else begin
                        r_state_d = R_WAIT;
                        r_wait_d  = WAIT_INIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_wait_q == 8'd0) begin
                    r_state_d    = R_DATA;
                    r_load       = 1'b1;
                    r_fetch_addr = r_addr_q;
                    rlast_d      = (r_beats_q == 8'd0);
                end else begin
                    r_wait_d = r_wait_q - 8'd1;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    if (r_beats_q != 8'd0) begin
                        r_addr_d     = r_addr_q + 32'd8;
                        r_beats_d    = r_beats_q - 8'd1;
                        r_load       = 1'b1;
                        r_fetch_addr = r_addr_q + 32'd8;
                        rlast_d      = (r_beats_q == 8'd1);
                    end else begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // Each beat is range-checked on its own; out-of-range beats read as zero.
        if (r_load) begin
            rvalid_d = 1'b1;
            if (in_range(r_fetch_addr)) begin
                rdata_d = mem_rdata;
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = 64'd0;
                rresp_d = RESP_DECERR;
            end
        end
    end

    // Write FSM: collect AW and W in either order, commit when both are present, hold B until taken.
    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wuser_d   = wuser_q;
        wlast_d   = wlast_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wbe   = 8'd0;
        mem_wdata = 64'd0;
        aw_hs     = AWVALID && awready_q;
        w_hs      = WVALID && wready_q;
        eff_addr  = aw_hs ? AWADDR : awaddr_q;
        eff_data  = w_hs ? WDATA : wdata_q;
        eff_user  = w_hs ? WUSER : wuser_q;
        eff_last  = w_hs ? WLAST : wlast_q;
        lane      = eff_addr[2:0];
        crosses   = (({1'b0, lane} + size_bytes(eff_user)) > 4'd8);
        unique case (w_state_q)
            W_IDLE: begin
                awready_d = !aw_got_q && !aw_hs;
                wready_d  = !w_got_q && !w_hs;
                if (aw_hs) begin
                    aw_got_d = 1'b1;
                    awaddr_d = AWADDR;
                end
                if (w_hs) begin
                    w_got_d = 1'b1;
                    wdata_d = WDATA;
                    wuser_d = WUSER;
                    wlast_d = WLAST;
                end
                if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    if (!in_range(eff_addr)) begin
                        bresp_d = RESP_DECERR;
                    end else if (crosses || !eff_last) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        bresp_d   = RESP_OKAY;
                        mem_we    = 1'b1;
                        mem_waddr = word_idx(eff_addr);
                        mem_wbe   = size_mask(eff_user) << lane;
                        mem_wdata = eff_data << {lane, 3'b000};
                    end
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read-side registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= 32'd0;
            r_beats_q <= 8'd0;
            r_wait_q  <= 8'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= 64'd0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_beats_q <= r_beats_d;
            r_wait_q  <= r_wait_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Write-side registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= 32'd0;
            wdata_q   <= 64'd0;
            wuser_q   <= 4'd0;
            wlast_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wuser_q   <= wuser_d;
            wlast_q   <= wlast_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;
    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized self-checking bench for axi_sram_slave against a word-array model
module tb_axi_sram_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 1;
    localparam longint      TOP   = longint'(BASE) + longint'(DEPTH) * 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen;
    logic [63:0] rdata, wdata;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]  wuser;

    always #5 clk = ~clk;

    axi_sram_slave #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .RD_LATENCY (LAT)
    ) dut (
        .ACLK   (clk),
        .ARESETn(rst_n),
        .ARVALID(arvalid),
        .ARREADY(arready),
        .ARADDR (araddr),
        .ARLEN  (arlen),
        .RVALID (rvalid),
        .RREADY (rready),
        .RDATA  (rdata),
        .RRESP  (rresp),
        .RLAST  (rlast),
        .AWVALID(awvalid),
        .AWREADY(awready),
        .AWADDR (awaddr),
        .WVALID (wvalid),
        .WREADY (wready),
        .WDATA  (wdata),
        .WLAST  (wlast),
        .WUSER  (wuser),
        .BVALID (bvalid),
        .BREADY (bready),
        .BRESP  (bresp)
    );

    int total = 0;
    int bad   = 0;
    logic [63:0] ref_mem [DEPTH];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference write: decide the response from the address and size rules, update bytes on OKAY.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [63:0] data,
                                               input logic [3:0] user, input logic last);
        int n;
        int ln;
        int idx;
        n = (user == 4'b0001) ? 1 : (user == 4'b0010) ? 2 : (user == 4'b0100) ? 4 : 8;
        if (longint'(addr) < longint'(BASE) || longint'(addr) >= TOP) return 2'b11;
        ln = int'(addr % 8);
        if (ln + n > 8 || !last) return 2'b10;
        idx = int'((longint'(addr) - longint'(BASE)) / 8);
        for (int b = 0; b < n; b++) ref_mem[idx][(ln + b) * 8 +: 8] = data[b * 8 +: 8];
        return 2'b00;
    endfunction

    function automatic void model_read(input longint addr, output logic [63:0] data, output logic [1:0] resp);
        if (addr < longint'(BASE) || addr >= TOP) begin
            data = 64'd0;
            resp = 2'b11;
        end else begin
            data = ref_mem[int'((addr - longint'(BASE)) / 8)];
            resp = 2'b00;
        end
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [63:0] data, input logic [3:0] user,
                            input logic last, input int awd, input int wd, input int bd,
                            output logic [1:0] resp_got);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        int c = 0;
        logic [1:0] exp;
        awaddr = addr; wdata = data; wuser = user; wlast = last; bready = 1'b0;
        while (!(aw_done && w_done) && c < 50) begin
            awvalid = (c >= awd) && !aw_done;
            wvalid  = (c >= wd) && !w_done;
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick();
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
            c++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        resp_got = bresp;
        if (!(aw_done && w_done)) begin
            check_val("wr_handshake_timeout", 0, 1);
            return;
        end
        exp = model_write(addr, data, user, last);
        check_val("wr_bvalid_next", bvalid, 1);
        check_val("wr_bresp", bresp, exp);
        for (int i = 0; i < bd; i++) begin
            tick();
            check_val("wr_bvalid_hold", bvalid, 1);
            check_val("wr_no_awready", awready, 0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_val("wr_bvalid_clr", bvalid, 0);
        check_val("wr_awready_back", awready, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int stall_beat,
                           input int stall_n, output logic [63:0] first_data,
                           output logic [63:0] last_data, output logic [1:0] last_resp);
        int c = 0;
        int lat;
        logic [63:0] ed;
        logic [1:0]  er;
        first_data = '0; last_data = '0; last_resp = '0;
        araddr = addr; arlen = len; arvalid = 1'b1; rready = 1'b0;
        while (!arready && c < 50) begin
            tick();
            c++;
        end
        if (!arready) begin
            arvalid = 1'b0;
            check_val("rd_arready_timeout", 0, 1);
            return;
        end
        tick();
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 20) begin
            tick();
            lat++;
        end
        check_val("rd_latency", lat, LAT);
        for (int i = 0; i <= int'(len); i++) begin
            model_read(longint'(addr & ~32'h7) + 8 * i, ed, er);
            check_val("rd_rvalid", rvalid, 1);
            check_val("rd_rdata", rdata, ed);
            check_val("rd_rresp", rresp, er);
            check_val("rd_rlast", rlast, (i == int'(len)));
            if (i == 0) first_data = rdata;
            last_data = rdata;
            last_resp = rresp;
            if (i == stall_beat) begin
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    check_val("rd_stall_data", rdata, ed);
                    check_val("rd_stall_last", rlast, (i == int'(len)));
                end
            end
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
        check_val("rd_rvalid_end", rvalid, 0);
        check_val("rd_arready_end", arready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  r;
        logic [63:0] fd, ld;
        logic [1:0]  lr;
        logic [31:0] a;
        logic [3:0]  u;
        int          sel;

        rst_n = 1'b0;
        arvalid = 0; araddr = 0; arlen = 0; rready = 0;
        awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wlast = 0; wuser = 0; bready = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_arready", arready, 0);
        check_val("rst_awready", awready, 0);
        check_val("rst_wready", wready, 0);
        check_val("rst_rvalid", rvalid, 0);
        check_val("rst_bvalid", bvalid, 0);
        check_val("rst_rdata", rdata, 0);
        check_val("rst_rlast", rlast, 0);
        check_val("rst_resps", {rresp, bresp}, 0);
        rst_n = 1'b1;
        tick();
        check_val("rel_arready", arready, 1);
        check_val("rel_awready", awready, 1);

        // Give the words the bench reads a known value.
        for (int i = 0; i < 32; i++)
            do_write(BASE + 32'(8 * i), {$urandom, $urandom}, 4'b1000, 1'b1, 0, 0, 0, r);
        for (int i = DEPTH - 4; i < DEPTH; i++)
            do_write(BASE + 32'(8 * i), {$urandom, $urandom}, 4'b1000, 1'b1, 0, 0, 0, r);

        // Full-word write and read-back
        do_write(32'h8000_0010, 64'h1122334455667788, 4'b1000, 1'b1, 0, 0, 0, r);
        check_val("dir_full_bresp", r, 2'b00);
        do_read(32'h8000_0010, 8'd0, -1, 0, fd, ld, lr);
        check_val("dir_full_rdata", fd, 64'h1122334455667788);

        // Halfword at lane 6
        do_write(32'h8000_0016, 64'h0000_0000_0000_ABCD, 4'b0010, 1'b1, 0, 0, 0, r);
        do_read(32'h8000_0010, 8'd0, -1, 0, fd, ld, lr);
        check_val("dir_sub_rdata", fd, 64'hABCD334455667788);

        // Four-beat burst with a stall on the first beat
        do_read(32'h8000_0000, 8'd3, 0, 2, fd, ld, lr);

        // Error responses
        do_write(32'h7000_0000, 64'h1, 4'b1000, 1'b1, 0, 0, 0, r);
        check_val("dir_decerr", r, 2'b11);
        do_write(32'h8000_0006, 64'hFFFF_FFFF, 4'b0100, 1'b1, 0, 0, 0, r);
        check_val("dir_slverr", r, 2'b10);
        do_read(32'h8000_0000, 8'd0, -1, 0, fd, ld, lr);
        do_write(32'h8000_0008, 64'h5, 4'b1000, 1'b0, 0, 0, 0, r);
        check_val("dir_wlast_err", r, 2'b10);
        do_read(BASE + 32'(DEPTH * 8 - 8), 8'd1, -1, 0, fd, ld, lr);
        check_val("dir_top_rresp", lr, 2'b11);
        check_val("dir_top_rdata", ld, 64'd0);

        // W three cycles ahead of AW, response held back five cycles
        do_write(32'h8000_0020, 64'hCAFE_F00D_1234_5678, 4'b1000, 1'b1, 3, 0, 5, r);
        do_write(32'h8000_0028, 64'h99, 4'b0001, 1'b1, 0, 2, 1, r);

        // Reset with a response pending and a burst in flight
        awaddr = BASE + 32'd40; wdata = 64'h0BAD_BEEF_0000_0001; wuser = 4'b1000; wlast = 1'b1;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        void'(model_write(BASE + 32'd40, 64'h0BAD_BEEF_0000_0001, 4'b1000, 1'b1));
        check_val("rstmid_bvalid_pre", bvalid, 1);
        araddr = BASE; arlen = 8'd7; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check_val("rstmid_rvalid_pre", rvalid, 1);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("rstmid_rvalid", rvalid, 0);
        check_val("rstmid_bvalid", bvalid, 0);
        check_val("rstmid_arready", arready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_val("rstmid_arready_after", arready, 1);
        check_val("rstmid_awready_after", awready, 1);
        check_val("rstmid_wready_after", wready, 1);
        do_read(BASE + 32'd40, 8'd0, -1, 0, fd, ld, lr);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      a = 32'h7000_0000 + $urandom_range(0, 255);
                else if (sel == 1) a = BASE + 32'(DEPTH * 8) + $urandom_range(0, 255);
                else if (sel < 4)  a = BASE + 32'((DEPTH - 4) * 8) + $urandom_range(0, 31);
                else               a = BASE + $urandom_range(0, 255);
                case ($urandom_range(0, 4))
                    0: u = 4'b1000;
                    1: u = 4'b0100;
                    2: u = 4'b0010;
                    3: u = 4'b0001;
                    default: u = 4'($urandom_range(0, 15));
                endcase
                do_write(a, {$urandom, $urandom}, u, ($urandom_range(0, 7) != 0),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), r);
            end else begin
                sel = int'($urandom_range(0, 5));
                if (sel == 0) begin
                    do_read(32'h7FFF_FFF8, 8'd2, int'($urandom_range(0, 2)),
                            int'($urandom_range(0, 2)), fd, ld, lr);
                end else if (sel == 1) begin
                    do_read(BASE + 32'((DEPTH - 4 + int'($urandom_range(0, 3))) * 8) + $urandom_range(0, 7),
                            8'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                            int'($urandom_range(0, 2)), fd, ld, lr);
                end else begin
                    do_read(BASE + 32'(int'($urandom_range(0, 24)) * 8) + $urandom_range(0, 7),
                            8'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 2)), fd, ld, lr);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
